// File: rtl/rv_regfile_pkg.sv
// Shared types and helpers for the parametrised integer register file.
package rv_regfile_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam int RADDR_W = 5;

   // True when the ISA register number exists in a file of nreg entries.
   function automatic logic addr_valid(input logic [RADDR_W-1:0] addr, input int nreg);
      return (int'(addr) < nreg);
   endfunction

endpackage

// File: rtl/rv_regfile_if.sv
// Decode/writeback-side bus of the register file: one write port, NRD read ports, clear control.
interface rv_regfile_if #(
   parameter int XLEN = 32,
   parameter int NRD  = 2
);
   import rv_regfile_pkg::*;

   logic                      WE;
   logic [RADDR_W-1:0]        WADDR;
   logic [XLEN-1:0]           WDATA;
   logic [NRD-1:0]            REN;
   logic [NRD*RADDR_W-1:0]    RADDR;
   logic [NRD*XLEN-1:0]       RDATA;
   logic                      CLR_REQ;
   logic                      READY;

   modport master (
      output WE, WADDR, WDATA, REN, RADDR, CLR_REQ,
      input  RDATA, READY
   );

   modport slave (
      input  WE, WADDR, WDATA, REN, RADDR, CLR_REQ,
      output RDATA, READY
   );

endinterface

// File: rtl/rv_regfile_rdport.sv
// One registered read port: x0/range masking, optional write bypass, and hold while REN is low.
module rv_regfile_rdport
   import rv_regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                i_run,
   input  logic                i_ren,
   input  logic [RADDR_W-1:0]  i_raddr,
   input  logic [XLEN-1:0]     i_arr_data,
   input  logic                i_we,
   input  logic [RADDR_W-1:0]  i_waddr,
   input  logic [XLEN-1:0]     i_wdata,
   output logic [XLEN-1:0]     o_rdata
);

   logic [XLEN-1:0] r_rdata;
   logic [XLEN-1:0] w_rdata_next;
   logic            w_addr_ok;
   logic            w_bypass_hit;

   assign w_addr_ok    = addr_valid(i_raddr, NREG) && (i_raddr != '0);
   assign w_bypass_hit = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

   // Outside RUN the array contents are meaningless, so reads return zero.
   always_comb begin
      w_rdata_next = '0;
      if (i_run && w_addr_ok) begin
         w_rdata_next = w_bypass_hit ? i_wdata : i_arr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_rdata <= '0;
      end else if (i_ren) begin
         r_rdata <= w_rdata_next;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/rv_regfile.sv
// Parametrised RV32I/E register file: reset-free array, post-reset clear sequencer, NRD read ports.
module rv_regfile
   import rv_regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic           CLK,
   input  logic           RST_N,
   rv_regfile_if.slave    rf_bus
);

   localparam int AW = $clog2(NREG);

   state_t           r_state;
   logic [AW-1:0]    r_cnt;
   logic [XLEN-1:0]  r_mem [NREG];

   logic             w_run;
   logic             w_wr_en;

   assign w_run        = (r_state == RUN);
   assign rf_bus.READY = w_run;
   assign w_wr_en      = RST_N && w_run && rf_bus.WE &&
                         addr_valid(rf_bus.WADDR, NREG) && (rf_bus.WADDR != '0);

   // Clear walks entries 1..NREG-1; entry 0 is never read back so it is skipped.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_cnt   <= AW'(1);
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= CLEAR;
            end
            CLEAR: begin
               if (r_cnt == AW'(NREG - 1)) begin
                  r_state <= RUN;
                  r_cnt   <= AW'(1);
               end else begin
                  r_cnt   <= r_cnt + AW'(1);
               end
            end
            RUN: begin
               if (rf_bus.CLR_REQ) begin
                  r_state <= CLEAR;
                  r_cnt   <= AW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= AW'(1);
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (r_state == CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_en) begin
         r_mem[rf_bus.WADDR[AW-1:0]] <= rf_bus.WDATA;
      end
   end

   logic [NRD-1:0][XLEN-1:0] w_rdata;

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [XLEN-1:0] w_arr_rd;

         // Index with the low bits only; out-of-range addresses are masked in the port.
         assign w_arr_rd = r_mem[rf_bus.RADDR[gi*RADDR_W +: AW]];

         rv_regfile_rdport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .BYPASS (BYPASS)
         ) u_rdport (
            .CLK        (CLK),
            .RST_N      (RST_N),
            .i_run      (w_run),
            .i_ren      (rf_bus.REN[gi]),
            .i_raddr    (rf_bus.RADDR[gi*RADDR_W +: RADDR_W]),
            .i_arr_data (w_arr_rd),
            .i_we       (rf_bus.WE),
            .i_waddr    (rf_bus.WADDR),
            .i_wdata    (rf_bus.WDATA),
            .o_rdata    (w_rdata[gi])
         );
      end
   endgenerate

   assign rf_bus.RDATA = w_rdata;

endmodule

// File: tb/tb_rv_regfile.sv
// Scoreboard bench: two register files (32 regs bypassed, 16 regs unbypassed) against a cycle-level model.
module tb_rv_regfile;

   logic CLK = 1'b0;
   logic RST_N;

   always #5 CLK = ~CLK;

   rv_regfile_if #(.XLEN(32), .NRD(2)) if_a ();
   rv_regfile_if #(.XLEN(32), .NRD(2)) if_b ();

   rv_regfile #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1)) dut_a (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .rf_bus (if_a)
   );

   rv_regfile #(.XLEN(32), .NREG(16), .NRD(2), .BYPASS(0)) dut_b (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .rf_bus (if_b)
   );

   typedef struct packed {
      logic [1:0]             rdy;
      logic [1:0][1:0][31:0]  rd;
      logic [31:0]            cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc_no = 0;

   // Reference: a file is "busy" for a number of edges, and its whole content is zero once busy.
   int          m_nreg [2] = '{32, 16};
   int          m_byp  [2] = '{1, 0};
   int          m_busy [2] = '{32, 16};
   logic [31:0] m_mem  [2][32];
   logic [31:0] m_rd   [2][2];

   task automatic model_step(input logic rst, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd, input logic [1:0] ren,
                             input logic [4:0] ra0, input logic [4:0] ra1, input logic clr);
      logic [4:0] ra [2];
      ra[0] = ra0;
      ra[1] = ra1;
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            m_busy[d] = m_nreg[d];
            for (int p = 0; p < 2; p++) m_rd[d][p] = 32'd0;
            for (int k = 0; k < 32; k++) m_mem[d][k] = 32'd0;
         end else begin
            bit run;
            run = (m_busy[d] == 0);
            for (int p = 0; p < 2; p++) begin
               if (ren[p]) begin
                  int a;
                  a = int'(ra[p]);
                  if (!run || a == 0 || a >= m_nreg[d])
                     m_rd[d][p] = 32'd0;
                  else if (m_byp[d] != 0 && we && wa == ra[p])
                     m_rd[d][p] = wd;
                  else
                     m_rd[d][p] = m_mem[d][a];
               end
            end
            if (run && we && wa != 5'd0 && int'(wa) < m_nreg[d])
               m_mem[d][wa] = wd;
            if (run && clr) begin
               for (int k = 0; k < 32; k++) m_mem[d][k] = 32'd0;
               m_busy[d] = m_nreg[d] - 1;
            end else if (!run) begin
               m_busy[d] = m_busy[d] - 1;
            end
         end
      end
   endtask

   task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [1:0] ren,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic clr);
      exp_t e;
      RST_N      = rst;
      if_a.WE    = we;   if_b.WE    = we;
      if_a.WADDR = wa;   if_b.WADDR = wa;
      if_a.WDATA = wd;   if_b.WDATA = wd;
      if_a.REN   = ren;  if_b.REN   = ren;
      if_a.RADDR = {ra1, ra0};
      if_b.RADDR = {ra1, ra0};
      if_a.CLR_REQ = clr;
      if_b.CLR_REQ = clr;
      model_step(rst, we, wa, wd, ren, ra0, ra1, clr);
      for (int d = 0; d < 2; d++) begin
         e.rdy[d] = (m_busy[d] == 0);
         for (int p = 0; p < 2; p++) e.rd[d][p] = m_rd[d][p];
      end
      e.cyc = 32'(cyc_no);
      q.push_back(e);
      cyc_no++;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] c, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("a_ready",  e.cyc, {31'd0, if_a.READY}, {31'd0, e.rdy[0]});
         chk("b_ready",  e.cyc, {31'd0, if_b.READY}, {31'd0, e.rdy[1]});
         chk("a_rdata0", e.cyc, if_a.RDATA[31:0],    e.rd[0][0]);
         chk("a_rdata1", e.cyc, if_a.RDATA[63:32],   e.rd[0][1]);
         chk("b_rdata0", e.cyc, if_b.RDATA[31:0],    e.rd[1][0]);
         chk("b_rdata1", e.cyc, if_b.RDATA[63:32],   e.rd[1][1]);
         $display("cyc %0d rdy=%b/%b a=%h,%h b=%h,%h", e.cyc, if_a.READY, if_b.READY,
                  if_a.RDATA[31:0], if_a.RDATA[63:32], if_b.RDATA[31:0], if_b.RDATA[63:32]);
      end
   end

   initial begin
      // Reset, then the initial clear with reads sweeping every register.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, 5'd1, 5'd2, 1'b0);
      for (int i = 0; i < 34; i++)
         cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'(i % 32), 5'((i + 7) % 32), 1'b0);
      for (int i = 1; i < 32; i++)
         cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'(i), 5'(32 - i), 1'b0);

      cyc(1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 1'b0);
      cyc(1'b1, 1'b1, 5'd0,  32'h00000001, 2'b11, 5'd5, 5'd5, 1'b0);
      cyc(1'b1, 1'b0, 5'd0,  32'd0,        2'b11, 5'd0, 5'd5, 1'b0);
      cyc(1'b1, 1'b1, 5'd7,  32'h12345678, 2'b11, 5'd7, 5'd7, 1'b0);
      cyc(1'b1, 1'b1, 5'd4,  32'h00004444, 2'b00, 5'd0, 5'd0, 1'b0);
      cyc(1'b1, 1'b1, 5'd20, 32'h0000FFFF, 2'b00, 5'd0, 5'd0, 1'b0);
      cyc(1'b1, 1'b0, 5'd0,  32'd0,        2'b11, 5'd20, 5'd4, 1'b0);

      // REN0 held low while its address moves; port 1 keeps tracking.
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'd5, 5'd7, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b10, 5'(i + 1), 5'(5 - i), 1'b0);
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'd7, 5'd5, 1'b0);

      // Runtime clear with a colliding write, then read the written register back.
      cyc(1'b1, 1'b1, 5'd3, 32'h000000AA, 2'b11, 5'd3, 5'd5, 1'b1);
      for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd5, 1'b1);
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd7, 1'b0);

      // Reset pulse part-way through the clear restarts the full sequence.
      cyc(1'b1, 1'b1, 5'd9, 32'h99999999, 2'b00, 5'd0, 5'd0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 5'd0, 32'd0, 2'b11, 5'd9, 5'd9, 1'b0);
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 2'b11, 5'd9, 5'd9, 1'b0);
      for (int i = 0; i < 34; i++) cyc(1'b1, 1'b1, 5'd9, 32'h0BADF00D, 2'b11, 5'd9, 5'd9, 1'b0);

      // Random traffic with occasional clears and resets.
      for (int i = 0; i < 3000; i++) begin
         logic        rst, we, clr;
         logic [4:0]  wa, ra0, ra1;
         logic [1:0]  ren;
         logic [31:0] wd;
         rst = ($urandom_range(0, 399) != 0);
         clr = ($urandom_range(0, 199) == 0);
         we  = 1'($urandom_range(0, 1));
         wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ra0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         ren = 2'($urandom_range(0, 3));
         wd  = $urandom;
         cyc(rst, we, wa, wd, ren, ra0, ra1, clr);
      end

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
